err_detect: RTL and testbench
=============================

// Module: err_detect
// PURPOSE
// - Timing-error detector feeding the phase-select FSM: compares main-flop data with shadow samples taken on the origin and leading clock phases.
// - Filters mismatches over a window and drives error_origin / error_leading, which the phase-select FSM samples on negedge clk.
// - Keeps per-channel error-event counters for debug readout.
// PARAMETERS
// - DW      8   data width compared per channel
// - THRESH  2   mismatches within one window needed to raise an error (>=1)
// - WINDOW  16  window length in cycles (>=2)
// - HOLD    4   cycles an error output stays high after its last qualifying mismatch (>=1)
// - CNT_W   8   width of the event counters
// PORTS
// - clk              in   1      system clock; all logic on posedge
// - rst              in   1      asynchronous reset, active-high
// - in_valid         in   1      d_* inputs valid this cycle
// - d_main           in   DW     main flop data
// - d_origin         in   DW     shadow sample, origin phase
// - d_leading        in   DW     shadow sample, leading phase
// - clr              in   1      synchronous clear of counters and channel FSMs
// - error_origin     out  1      filtered origin-phase error (registered)
// - error_leading    out  1      filtered leading-phase error (registered)
// - err_cnt_origin   out  CNT_W  origin error events, saturating
// - err_cnt_leading  out  CNT_W  leading error events, saturating
// BEHAVIOUR
// - Reset: all outputs 0, window counter 0, hit/hold counters 0, both FSMs IDLE. Asynchronous; takes effect immediately, including mid-FLAG.
// - Stage 1 (posedge): mis_o <= in_valid & |(d_main^d_origin); mis_l <= in_valid & |(d_main^d_leading). in_valid=0 gives no mismatch.
// - Window counter: free-running 0..WINDOW-1. wrap = (count==WINDOW-1). Shared by both channels.
// - Per-channel FSM, channels fully independent, both may assert together:
//   IDLE : mis -> THRESH==1 ? FLAG : COUNT with hit=1.
//   COUNT: mis -> hit+1; if hit+1==THRESH -> FLAG.
//          wrap with threshold not reached -> IDLE, hit=0. A mismatch on the wrap cycle is counted first; it is discarded if the threshold is still not reached.
//   FLAG : error_x=1; hold counts from 0. hold==HOLD-1 with no mis -> IDLE, hit=0.
//          mis in FLAG -> hold restarts at 0 (extension); no new event counted. FLAG ignores wrap.
// - Latency: the qualifying mismatch is sampled at edge k. mis_* is valid after edge k. error_x goes high after edge k+1.
//   With no further mismatch, error_x stays high exactly HOLD cycles.
// - error_x = (state==FLAG), driven from a flop. Changes only on posedge, so it is stable at the consumer's negedge.
// - err_cnt_x: +1 on each IDLE/COUNT->FLAG transition. Saturates at 2^CNT_W-1; no wrap.
// - clr: highest synchronous priority. Next edge zeroes counters, hit and hold, and sends both FSMs to IDLE. Window counter is not reset.
//   Stage-1 flops still capture the current inputs.
// TESTING
// - Reset: rst pulse while error_origin=1 -> error_origin=0 and counters 0 without waiting for clk; FSMs IDLE after release.
// - Defaults: origin mismatch at cycles 2 and 5 (same window) -> error_origin=1 after edge 6 for exactly 4 cycles; err_cnt_origin=1; error_leading stays 0.
// - Window expiry: one leading mismatch at cycle 3, next at cycle 20 -> no error_leading; hit is 0 after cycle 15 (wrap).
// - Extension: mismatch on the 3rd FLAG cycle -> error held 4 more cycles (6 total); err_cnt unchanged.
// - in_valid=0 with d_main!=d_origin and d_main!=d_leading for 20 cycles -> both errors 0, counters 0.
// - Saturation/clr: CNT_W=2, THRESH=1, 5 separated origin events -> err_cnt_origin=3; clr pulse -> 0 and error_origin=0 at the next edge.

Source files
------------

// File: rtl/err_detect.sv
// err_detect: timing-error detector comparing main-flop data against origin/leading shadow samples.
// Each channel filters mismatches over a shared window and raises a registered error flag
// that the phase-select FSM samples on negedge clk. Per-channel event counters saturate.
// Ports:
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   in_valid            d_* inputs valid this cycle
//   d_main              main flop data
//   d_origin            shadow sample, origin phase
//   d_leading           shadow sample, leading phase
//   clr                 synchronous clear of counters and channel FSMs
//   error_origin        filtered origin-phase error
//   error_leading       filtered leading-phase error
//   err_cnt_origin      origin error events, saturating
//   err_cnt_leading     leading error events, saturating
module err_detect #(
    parameter int DW     = 8,
    parameter int THRESH = 2,
    parameter int WINDOW = 16,
    parameter int HOLD   = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    d_main,
    input  logic [DW-1:0]    d_origin,
    input  logic [DW-1:0]    d_leading,
    input  logic             clr,
    output logic             error_origin,
    output logic             error_leading,
    output logic [CNT_W-1:0] err_cnt_origin,
    output logic [CNT_W-1:0] err_cnt_leading
);
    localparam int WW = $clog2(WINDOW);
    localparam int TW = $clog2(THRESH + 1);
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {IDLE, COUNT, FLAG} state_t;

    logic [WW-1:0]    r_win;
    logic             w_wrap;
    logic [DW-1:0]    w_shadow [2];
    logic [1:0]       w_err;
    logic [CNT_W-1:0] w_cnt [2];

    assign w_wrap      = r_win == WW'(WINDOW - 1);
    assign w_shadow[0] = d_origin;
    assign w_shadow[1] = d_leading;

    // window counter is deliberately untouched by clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_win <= '0;
        else
            r_win <= w_wrap ? '0 : r_win + 1'b1;
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t           r_state;
        logic             r_mis;
        logic             r_err;
        logic [TW-1:0]    r_hit;
        logic [HW-1:0]    r_hold;
        logic [CNT_W-1:0] r_cnt;
        logic             w_to_flag;

        // hit is 0 in IDLE, so this also covers THRESH==1 straight from IDLE
        assign w_to_flag = r_mis && r_state != FLAG && r_hit == TW'(THRESH - 1);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_mis   <= 1'b0;
                r_state <= IDLE;
                r_err   <= 1'b0;
                r_hit   <= '0;
                r_hold  <= '0;
                r_cnt   <= '0;
            end else begin
                r_mis <= in_valid & |(d_main ^ w_shadow[c]);
                if (clr) begin
                    r_state <= IDLE;
                    r_err   <= 1'b0;
                    r_hit   <= '0;
                    r_hold  <= '0;
                    r_cnt   <= '0;
                end else if (r_state == FLAG) begin
                    // a mismatch while flagged extends the hold, ignoring the window
                    if (r_mis)
                        r_hold <= '0;
                    else if (r_hold == HW'(HOLD - 1)) begin
                        r_state <= IDLE;
                        r_err   <= 1'b0;
                        r_hit   <= '0;
                    end else
                        r_hold <= r_hold + 1'b1;
                end else if (w_to_flag) begin
                    r_state <= FLAG;
                    r_err   <= 1'b1;
                    r_hit   <= '0;
                    r_hold  <= '0;
                    r_cnt   <= &r_cnt ? r_cnt : r_cnt + 1'b1;
                end else if (r_state == COUNT && w_wrap) begin
                    // a mismatch on the wrap cycle that misses the threshold is dropped
                    r_state <= IDLE;
                    r_hit   <= '0;
                end else if (r_mis) begin
                    r_state <= COUNT;
                    r_hit   <= r_hit + 1'b1;
                end
            end
        end

        assign w_err[c] = r_err;
        assign w_cnt[c] = r_cnt;
    end

    assign error_origin    = w_err[0];
    assign error_leading   = w_err[1];
    assign err_cnt_origin  = w_cnt[0];
    assign err_cnt_leading = w_cnt[1];
endmodule

// File: tb/tb_err_detect.sv
// tb_err_detect: table-driven bench for err_detect plus sequences for saturation, clr and async reset.
module tb_err_detect;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] d_main = '0, d_origin = '0, d_leading = '0;
    logic       clr = 1'b0;
    logic       eo, el, eo2, el2;
    logic [7:0] co, cl;
    logic [1:0] co2, cl2;

    int n_vec = 0;
    int n_bad = 0;

    err_detect dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_main(d_main), .d_origin(d_origin),
        .d_leading(d_leading), .clr(clr), .error_origin(eo), .error_leading(el),
        .err_cnt_origin(co), .err_cnt_leading(cl)
    );

    err_detect #(.THRESH(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_main(d_main), .d_origin(d_origin),
        .d_leading(d_leading), .clr(clr), .error_origin(eo2), .error_leading(el2),
        .err_cnt_origin(co2), .err_cnt_leading(cl2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [7:0] xo;
        logic [7:0] xl;
        logic       clr;
        logic       eo;
        logic       el;
        logic [7:0] co;
        logic [7:0] cl;
    } vec_t;

    vec_t tv [1:96];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0d, want %0d", name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [7:0] xo, input logic [7:0] xl, input logic c);
        logic [7:0] base;
        @(negedge clk);
        base      = 8'($urandom_range(0, 255));
        in_valid  = v;
        d_main    = base;
        d_origin  = base ^ xo;
        d_leading = base ^ xl;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 1; i <= 96; i++) begin
            tv[i] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
            tv[i].eo = (i >= 6 && i <= 9) || (i >= 48 && i <= 51) || (i >= 69 && i <= 74);
            tv[i].el = (i >= 31 && i <= 34) || (i >= 48 && i <= 51);
            tv[i].co = i < 6 ? 8'd0 : i < 48 ? 8'd1 : i < 69 ? 8'd2 : i < 76 ? 8'd3 : 8'd0;
            tv[i].cl = i < 31 ? 8'd0 : i < 48 ? 8'd1 : i < 76 ? 8'd2 : 8'd0;
            if (i >= 76) begin
                tv[i].vld = 1'b0;
                tv[i].xo  = 8'hFF;
                tv[i].xl  = 8'h01;
            end
        end
        tv[2].xo  = 8'h01;
        tv[5].xo  = 8'h80;
        tv[3].xl  = 8'h10;
        tv[20].xl = 8'hFF;
        tv[30].xl = 8'h02;
        tv[40].xo = 8'h40;
        tv[40].xl = 8'h04;
        tv[47].xo = 8'hC3;
        tv[47].xl = 8'hC3;
        tv[66].xo = 8'h20;
        tv[68].xo = 8'h08;
        tv[70].xo = 8'h01;
        tv[76].clr = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_err_o", 0, int'(eo), 0);
        chk("reset_err_l", 0, int'(el), 0);
        chk("reset_cnt_o", 0, int'(co), 0);
        chk("reset_cnt_l", 0, int'(cl), 0);

        for (int i = 1; i <= 96; i++) begin
            apply(tv[i].vld, tv[i].xo, tv[i].xl, tv[i].clr);
            chk("err_o", i, int'(eo), int'(tv[i].eo));
            chk("err_l", i, int'(el), int'(tv[i].el));
            chk("cnt_o", i, int'(co), int'(tv[i].co));
            chk("cnt_l", i, int'(cl), int'(tv[i].cl));
        end

        apply(1'b1, 8'h00, 8'h00, 1'b1);
        chk("sat_clr_cnt", 0, int'(co2), 0);
        chk("sat_clr_err", 0, int'(eo2), 0);
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, 8'hFF, 8'h00, 1'b0);
            apply(1'b1, 8'h00, 8'h00, 1'b0);
            chk("sat_err_hi", k, int'(eo2), 1);
            chk("sat_cnt", k, int'(co2), k < 3 ? k + 1 : 3);
            repeat (6) apply(1'b1, 8'h00, 8'h00, 1'b0);
            chk("sat_err_lo", k, int'(eo2), 0);
        end
        apply(1'b1, 8'h55, 8'h00, 1'b0);
        apply(1'b1, 8'h00, 8'h00, 1'b0);
        chk("clr_pre_err", 0, int'(eo2), 1);
        apply(1'b1, 8'h00, 8'h00, 1'b1);
        chk("clr_err2", 0, int'(eo2), 0);
        chk("clr_cnt2", 0, int'(co2), 0);
        chk("clr_cnt1", 0, int'(co), 0);
        chk("clr_err1", 0, int'(eo), 0);

        apply(1'b1, 8'h11, 8'h00, 1'b0);
        apply(1'b1, 8'h22, 8'h00, 1'b0);
        apply(1'b1, 8'h00, 8'h00, 1'b0);
        chk("pre_rst_err", 0, int'(eo), 1);
        chk("pre_rst_cnt", 0, int'(co), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_err_o", 0, int'(eo), 0);
        chk("async_cnt_o", 0, int'(co), 0);
        chk("async_err2", 0, int'(eo2), 0);
        chk("async_cnt2", 0, int'(co2), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) apply(1'b1, 8'h00, 8'h00, 1'b0);
        chk("post_rst_err", 0, int'(eo), 0);
        apply(1'b1, 8'h0F, 8'h00, 1'b0);
        apply(1'b1, 8'h00, 8'h00, 1'b0);
        chk("post_rst_single", 0, int'(eo), 0);
        chk("post_rst_dut2", 0, int'(eo2), 1);
        chk("post_rst_cnt2", 0, int'(co2), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
